oled_pixel_serializer: RTL and testbench

OLED_PIXEL_SERIALIZER -- requirements
Module: oled_pixel_serializer

---
 rtl/oled_pixel_serializer_pkg.sv | 28 ++
 rtl/spi_bit_shifter.sv | 88 ++++++++
 rtl/oled_pixel_serializer.sv | 155 +++++++++++++++
 tb/tb_oled_pixel_serializer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pixel_serializer_pkg.sv
// oled_pixel_serializer_pkg
// Shared definitions for the OLED pixel serializer and the colour stages
// that feed it: the serializer FSM state encoding, default panel geometry,
// pixel word width and RGB565 colour constants.
package oled_pixel_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_ADVANCE = 2'd3
    } state_t;

    localparam int DEF_WIDTH  = 96;
    localparam int DEF_HEIGHT = 64;
    localparam int PIXEL_BITS = 16;

    // RGB565: [15:11] red, [10:5] green, [4:0] blue
    localparam logic [PIXEL_BITS-1:0] RGB565_BLACK   = 16'h0000;
    localparam logic [PIXEL_BITS-1:0] RGB565_RED     = 16'hF800;
    localparam logic [PIXEL_BITS-1:0] RGB565_GREEN   = 16'h07E0;
    localparam logic [PIXEL_BITS-1:0] RGB565_BLUE    = 16'h001F;
    localparam logic [PIXEL_BITS-1:0] RGB565_WHITE   = 16'hFFFF;
    localparam logic [PIXEL_BITS-1:0] RGB565_YELLOW  = 16'hFFE0;
    localparam logic [PIXEL_BITS-1:0] RGB565_CYAN    = 16'h07FF;
    localparam logic [PIXEL_BITS-1:0] RGB565_MAGENTA = 16'hF81F;

endpackage

// File: rtl/spi_bit_shifter.sv
// spi_bit_shifter
// Serialises one PIXEL_BITS word MSB first in SPI mode 0 (sclk idles low,
// data changes on the falling edge, sampled by the panel on the rising edge).
// Each sclk half-period lasts CLK_DIV clock cycles, so a word takes
// 2*PIXEL_BITS*CLK_DIV cycles from load to done.
//
// Ports
//   clock   in   system clock
//   resetn  in   asynchronous active-low reset
//   load    in   one-cycle strobe: capture data and start shifting
//   data    in   word to send
//   sclk    out  serial clock
//   sdin    out  serial data (MSB of the shift register)
//   active  out  high while a word is being shifted
//   done    out  combinational pulse on the cycle whose edge ends the last
//                sclk falling edge; active drops on that same edge
module spi_bit_shifter
    import oled_pixel_serializer_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  load,
    input  logic [PIXEL_BITS-1:0] data,
    output logic                  sclk,
    output logic                  sdin,
    output logic                  active,
    output logic                  done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0]       BIT_LAST = 5'(PIXEL_BITS - 1);

    logic [PIXEL_BITS-1:0] shreg;
    logic [DIV_W-1:0]      div_cnt;
    logic [4:0]            bit_cnt;
    logic                  sclk_q;
    logic                  active_q;
    logic                  half_end;

    assign half_end = active_q && (div_cnt == DIV_LAST);
    // Falling edge of the last bit: sclk is high and its half-period ends now.
    assign done     = half_end && sclk_q && (bit_cnt == BIT_LAST);

    assign sclk   = sclk_q;
    assign sdin   = shreg[PIXEL_BITS-1];
    assign active = active_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            shreg    <= RGB565_BLACK;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sclk_q   <= 1'b0;
            active_q <= 1'b0;
        end else if (load) begin
            // First bit is on sdin immediately, well before the first rise.
            shreg    <= data;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sclk_q   <= 1'b0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (half_end) begin
                div_cnt <= '0;
                if (sclk_q) begin
                    // Falling edge: advance to the next bit while sclk goes low.
                    sclk_q <= 1'b0;
                    if (bit_cnt == BIT_LAST) begin
                        active_q <= 1'b0;
                        bit_cnt  <= '0;
                        shreg    <= RGB565_BLACK;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        shreg   <= {shreg[PIXEL_BITS-2:0], 1'b0};
                    end
                end else begin
                    sclk_q <= 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/oled_pixel_serializer.sv
// oled_pixel_serializer
// Walks the panel raster (x fastest, then y), asks an external colour stage
// for each pixel through x/y, captures the RGB565 answer after
// COLOR_LATENCY+1 cycles and sends it over SPI with cs_n framing each pixel.
// Frames repeat back to back while enable is high; a frame that has started
// always runs to completion.
//
// Valid/ready contract with the colour stage: there is no handshake.
// x/y are registered and change only on entry to FETCH; pixel_data must be
// valid COLOR_LATENCY+1 cycles later and is sampled on that single edge only.
//
// Ports
//   clock        in   system clock
//   resetn       in   asynchronous active-low reset
//   enable       in   start / continue frame streaming
//   x, y         out  coordinates of the pixel being fetched
//   pixel_data   in   RGB565 colour for x/y
//   sclk, sdin   out  SPI clock and data
//   cs_n         out  active-low chip select, low only while shifting
//   frame_begin  out  one-cycle pulse as the fetch of pixel (0,0) starts
//   busy         out  high whenever the FSM is not in IDLE
//   fsm_state    out  current FSM state, for observation
module oled_pixel_serializer
    import oled_pixel_serializer_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int COLOR_LATENCY = 1,
    parameter int WIDTH         = DEF_WIDTH,
    parameter int HEIGHT        = DEF_HEIGHT
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  enable,
    output logic [6:0]            x,
    output logic [5:0]            y,
    input  logic [PIXEL_BITS-1:0] pixel_data,
    output logic                  sclk,
    output logic                  sdin,
    output logic                  cs_n,
    output logic                  frame_begin,
    output logic                  busy,
    output state_t                fsm_state
);

    localparam int LAT_W = $clog2(COLOR_LATENCY + 2);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(COLOR_LATENCY);
    localparam logic [6:0]       X_LAST   = 7'(WIDTH - 1);
    localparam logic [5:0]       Y_LAST   = 6'(HEIGHT - 1);

    state_t           state_q, state_d;
    logic [6:0]       x_q, x_d;
    logic [5:0]       y_q, y_d;
    logic             fb_q, fb_d;
    logic [LAT_W-1:0] wait_q, wait_d;
    logic             load;
    logic             shift_active;
    logic             shift_done;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            fb_q    <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fb_q    <= fb_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        fb_d    = 1'b0;
        wait_d  = wait_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    x_d     = '0;
                    y_d     = '0;
                    fb_d    = 1'b1;
                    wait_d  = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // wait_q counts cycles since x/y changed; the colour stage
                // answer is valid on the edge where it reaches COLOR_LATENCY.
                if (wait_q == LAT_LAST) begin
                    load    = 1'b1;
                    wait_d  = '0;
                    state_d = ST_SHIFT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    state_d = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                wait_d  = '0;
                state_d = ST_FETCH;
                if (x_q < X_LAST) begin
                    x_d = x_q + 1'b1;
                end else if (y_q < Y_LAST) begin
                    x_d = '0;
                    y_d = y_q + 1'b1;
                end else begin
                    // End of frame: restart seamlessly or park at (0,0).
                    x_d = '0;
                    y_d = '0;
                    if (enable) begin
                        fb_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    spi_bit_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clock  (clock),
        .resetn (resetn),
        .load   (load),
        .data   (pixel_data),
        .sclk   (sclk),
        .sdin   (sdin),
        .active (shift_active),
        .done   (shift_done)
    );

    // The shifter is active exactly while the FSM is in SHIFT, and its
    // active flag is a flop, so cs_n is glitch-free and resets at once.
    assign cs_n        = ~shift_active;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_begin = fb_q;
    assign busy        = (state_q != ST_IDLE);
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_oled_pixel_serializer.sv
module tb_oled_pixel_serializer;
    import oled_pixel_serializer_pkg::*;

    localparam int TB_W = 96;
    localparam int TB_H = 2;

    logic        clock = 1'b0;
    logic        resetn;
    logic        enable;
    logic [15:0] pixel_data;
    logic [6:0]  x;
    logic [5:0]  y;
    logic        sclk;
    logic        sdin;
    logic        cs_n;
    logic        frame_begin;
    logic        busy;
    state_t      fsm_state;

    int total = 0;
    int bad   = 0;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    oled_pixel_serializer #(
        .CLK_DIV       (4),
        .COLOR_LATENCY (1),
        .WIDTH         (TB_W),
        .HEIGHT        (TB_H)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .enable      (enable),
        .x           (x),
        .y           (y),
        .pixel_data  (pixel_data),
        .sclk        (sclk),
        .sdin        (sdin),
        .cs_n        (cs_n),
        .frame_begin (frame_begin),
        .busy        (busy),
        .fsm_state   (fsm_state)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] pat(input int p);
        return 16'((p * 40503) ^ 23130);
    endfunction

    // Called on the sample before FETCH is entered. Follows one pixel from
    // fetch to ADVANCE, rebuilding the word from sdin at each sclk rise.
    task automatic run_pixel(input logic [15:0] hold, input bit toggle,
                             input bit exp_fb, input int ex, input int ey);
        logic [15:0] word;
        int          cnt;
        int          rises;
        int          bad_edges;
        logic        prev_sclk;
        logic        prev_sdin;
        pixel_data = hold;
        step();
        check("fetch_state", fsm_state, ST_FETCH);
        check("frame_begin", frame_begin, exp_fb);
        check("fetch_x", x, ex);
        check("fetch_y", y, ey);
        check("fetch_cs_n", cs_n, 1);
        check("fetch_busy", busy, 1);
        step();
        check("frame_begin_drop", frame_begin, 0);
        check("fetch_wait_cs_n", cs_n, 1);
        step();
        check("capture_cs_n", cs_n, 0);
        check("shift_sclk_idle", sclk, 0);
        word      = '0;
        cnt       = 0;
        rises     = 0;
        bad_edges = 0;
        prev_sclk = 1'b0;
        prev_sdin = sdin;
        while (cs_n === 1'b0 && cnt < 1000) begin
            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                word = {word[14:0], sdin};
                rises++;
            end
            if (sdin !== prev_sdin && sclk === 1'b1) bad_edges++;
            prev_sclk = sclk;
            prev_sdin = sdin;
            if (toggle) pixel_data = cnt[0] ? 16'h07E0 : 16'h001F;
            step();
            cnt++;
        end
        check("cs_low_cycles", cnt, 128);
        check("sclk_rises", rises, 16);
        check("sdin_change_sclk_high", bad_edges, 0);
        check("pixel_word", word, hold);
        check("advance_state", fsm_state, ST_ADVANCE);
        check("advance_sclk", sclk, 0);
        check("advance_cs_n", cs_n, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int rises;
        int guard;
        logic prev_sclk;

        resetn     = 1'b0;
        enable     = 1'b0;
        pixel_data = 16'h0000;

        // Reset values before any clock edge
        #3;
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_sdin", sdin, 0);
        check("rst_busy", busy, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_frame_begin", frame_begin, 0);
        check("rst_state", fsm_state, ST_IDLE);
        #9;
        resetn = 1'b1;

        // Idle with enable low for 100 cycles
        for (int i = 0; i < 100; i++) begin
            step();
            check("idle_cs_n", cs_n, 1);
            check("idle_sclk", sclk, 0);
            check("idle_busy", busy, 0);
            check("idle_x", x, 0);
            check("idle_y", y, 0);
            check("idle_frame_begin", frame_begin, 0);
        end

        // Single red pixel, then a pixel with pixel_data toggling during SHIFT
        enable = 1'b1;
        run_pixel(RGB565_RED, 1'b0, 1'b1, 0, 0);
        run_pixel(RGB565_GREEN, 1'b1, 1'b0, 1, 0);

        // Rest of frame 1, crossing the row wrap at (95,0) -> (0,1)
        for (int p = 2; p < TB_W * TB_H; p++) begin
            run_pixel(pat(p), 1'b0, 1'b0, p % TB_W, p / TB_W);
        end

        // Frame 2 follows with no gap; enable drops mid-frame
        for (int p = 0; p < TB_W * TB_H; p++) begin
            if (p == 5) enable = 1'b0;
            run_pixel(pat(p + 7), 1'b0, (p == 0), p % TB_W, p / TB_W);
        end

        // Frame end with enable low parks in IDLE at (0,0)
        step();
        check("end_state", fsm_state, ST_IDLE);
        check("end_busy", busy, 0);
        check("end_x", x, 0);
        check("end_y", y, 0);
        check("end_cs_n", cs_n, 1);
        check("end_frame_begin", frame_begin, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("parked_busy", busy, 0);
            check("parked_frame_begin", frame_begin, 0);
        end

        // Mid-shift reset on pixel (1,0) after its 7th sclk rise
        enable = 1'b1;
        run_pixel(RGB565_WHITE, 1'b0, 1'b1, 0, 0);
        step();
        check("mid_fetch_x", x, 1);
        step();
        step();
        check("mid_capture_cs_n", cs_n, 0);
        rises     = 0;
        guard     = 0;
        prev_sclk = 1'b0;
        while (rises < 7 && guard < 200) begin
            if (sclk === 1'b1 && prev_sclk === 1'b0) rises++;
            prev_sclk = sclk;
            if (rises < 7) begin
                step();
                guard++;
            end
        end
        check("mid_rises_reached", rises, 7);
        check("mid_sclk_high", sclk, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_cs_n", cs_n, 1);
        check("mid_rst_sclk", sclk, 0);
        check("mid_rst_sdin", sdin, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_x", x, 0);
        check("mid_rst_y", y, 0);
        check("mid_rst_state", fsm_state, ST_IDLE);
        #2;
        resetn = 1'b1;
        run_pixel(RGB565_BLUE, 1'b0, 1'b1, 0, 0);
        run_pixel(RGB565_MAGENTA, 1'b0, 1'b0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
